axi_ar_crossbar: RTL and testbench
==================================

# axi_ar_crossbar

Parametrised AXI read-address (AR) channel crossbar connecting NUM_MASTERS masters to NUM_SLAVES slaves. It decodes each master's ARADDR to a slave index and runs an independent round-robin arbiter per slave. Each slave port has a registered output stage, and addresses outside the populated slave range are answered with a decode-error pulse. It sits between the CPU/DMA masters and the peripheral slaves, in place of the single-master AR router.

## Interface
Parameters:
- NUM_MASTERS, 2: number of master ports, 1..8.
- NUM_SLAVES, 4: number of slave ports, 1..2^SEL_BITS.
- ADDR_WIDTH, 32: address width.
- SEL_BITS, 2: number of top address bits used as the slave index.
- MID_W, derived: max(1, clog2(NUM_MASTERS)). This is the width of the master-ID tag.

Ports:
- ACLK, input, 1: clock. All logic is on the rising edge.
- ARESET, input, 1: asynchronous, active-high reset.
- M_AXI_ARADDR, input, NUM_MASTERS*ADDR_WIDTH: per-master read address.
- M_AXI_ARPROT, input, NUM_MASTERS*3: per-master protection bits.
- M_AXI_ARVALID, input, NUM_MASTERS: per-master valid.
- M_AXI_ARREADY, output, NUM_MASTERS: per-master ready (combinational).
- M_AXI_ARDECERR, output, NUM_MASTERS: one-cycle registered decode-error pulse.
- S_AXI_ARADDR, output, NUM_SLAVES*ADDR_WIDTH: registered address to each slave.
- S_AXI_ARPROT, output, NUM_SLAVES*3: registered protection bits.
- S_AXI_ARMID, output, NUM_SLAVES*MID_W: index of the master that issued the request.
- S_AXI_ARVALID, output, NUM_SLAVES: registered valid to each slave.
- S_AXI_ARREADY, input, NUM_SLAVES: slave ready.

## Operation
- **Decode:** target slave index = ARADDR[ADDR_WIDTH-1 -: SEL_BITS]. An index ≥ NUM_SLAVES is a decode error.
- **Per-slave FSM states:** IDLE and BUSY.
- **IDLE:**
  - Request vector = {m : M_ARVALID[m] and the decoded index of m equals this slave}.
  - If the vector is non-zero, the round-robin arbiter picks one master g.
  - M_ARREADY[g] = 1 in that same cycle, so the handshake completes on this edge.
  - S_ARADDR, S_ARPROT and S_ARMID are loaded from master g.
  - S_ARVALID is set to 1 and the FSM moves to BUSY.
- **BUSY:**
  - S_ARVALID, S_ARADDR, S_ARPROT and S_ARMID are held stable.
  - M_ARREADY contributions from this slave = 0.
  - On S_ARVALID & S_ARREADY: S_ARVALID is cleared to 0 and the FSM returns to IDLE.
- **Round robin:**
  - Each slave keeps a last-grant pointer, reset to NUM_MASTERS-1, so master 0 wins first.
  - Search order: last+1, last+2, … modulo NUM_MASTERS.
  - The pointer updates to g only on a grant.
- **Decode error:**
  - M_ARREADY[m] = 1 combinationally whenever M_ARVALID[m] is set and the index is invalid. No slave is touched.
  - M_ARDECERR[m] = 1 for exactly the next cycle.
- **Ready merge:** M_ARREADY[m] = OR of the per-slave grants to m, OR'd with the decode-error accept for m. Each master targets at most one slave, so at most one source is active.
- **Slave independence:** different slaves grant different masters in the same cycle without interaction.
- **Reset:**
  - Asserting ARESET at any time clears every output register asynchronously: S_ARVALID=0, S_ARADDR=0, S_ARPROT=0, S_ARMID=0, M_ARDECERR=0.
  - All FSMs go to IDLE and the pointers go to NUM_MASTERS-1.
  - An in-flight BUSY transaction is dropped.
  - M_ARREADY=0 while ARESET=1.

## Timing
- Master acceptance to S_ARVALID high: 1 cycle.
- With a slave holding ARREADY=1, the minimum S_ARVALID pulse is 1 cycle.
- After the slave handshake, the FSM spends 1 cycle in IDLE before it can accept the next request. Maximum throughput per slave is one request every 2 cycles.
- Decode error: M_ARREADY is asserted in the request cycle and M_ARDECERR in the following cycle.
- A master whose M_ARVALID drops before it is granted is not granted. Dropping is an AXI violation, but the arbiter must tolerate it.
- Arbitration, decode and the M_ARREADY path are combinational within one cycle. All slave-side outputs are flop outputs.

## Test plan
- **Reset:** assert ARESET mid-BUSY with S_ARVALID=1.
  - All S_* outputs and M_ARDECERR go to 0 immediately.
  - After release, master 0 wins the first contention.
- **Single request:** M0 ARADDR=0x4000_1234, ARVALID=1, ARPROT=3'b010.
  - M_ARREADY[0]=1 in the same cycle.
  - Next cycle: S_ARVALID[1]=1, S_ARADDR[1]=0x4000_1234, S_ARPROT[1]=3'b010, S_ARMID[1]=0.
  - Clears one cycle after S_ARREADY[1]=1.
- **Contention:** M0 and M1 both continuously request slave 0, and slave 0 holds ARREADY=1.
  - Grants alternate M0, M1, M0, M1.
  - S_ARMID[0] sequence = 0, 1, 0, 1, with one request every 2 cycles.
- **Backpressure:** with S_ARREADY[2]=0 for 5 cycles, S_ARVALID[2] and S_ARADDR[2] stay stable and the M1 request to slave 2 sees ARREADY=0. Release: handshake, then M1 accepted the next cycle.
- **Decode error:** with NUM_SLAVES=3, M1 ARADDR=0xC000_0000.
  - M_ARREADY[1]=1 in the same cycle.
  - M_ARDECERR[1]=1 for 1 cycle.
  - No S_ARVALID asserts.
- **Parallel slaves:** in the same cycle, M0 targets slave 0 and M1 targets slave 3. Both are accepted, and both S_ARVALID go high on the next cycle.

Source files
------------

// File: rtl/axi_ar_crossbar.sv
// AXI read-address crossbar: decodes each master's ARADDR to a slave,
// round-robin arbitrates per slave and drives a registered AR stage per slave.
module axi_ar_crossbar #(
    parameter int NUM_MASTERS = 2,
    parameter int NUM_SLAVES  = 4,
    parameter int ADDR_WIDTH  = 32,
    parameter int SEL_BITS    = 2,
    localparam int MID_W      = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
    input  logic                              ACLK,
    input  logic                              ARESET,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] M_AXI_ARADDR,
    input  logic [NUM_MASTERS*3-1:0]          M_AXI_ARPROT,
    input  logic [NUM_MASTERS-1:0]            M_AXI_ARVALID,
    output logic [NUM_MASTERS-1:0]            M_AXI_ARREADY,
    output logic [NUM_MASTERS-1:0]            M_AXI_ARDECERR,
    output logic [NUM_SLAVES*ADDR_WIDTH-1:0]  S_AXI_ARADDR,
    output logic [NUM_SLAVES*3-1:0]           S_AXI_ARPROT,
    output logic [NUM_SLAVES*MID_W-1:0]       S_AXI_ARMID,
    output logic [NUM_SLAVES-1:0]             S_AXI_ARVALID,
    input  logic [NUM_SLAVES-1:0]             S_AXI_ARREADY
);

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    logic [NUM_MASTERS-1:0][SEL_BITS-1:0]    sel;
    logic [NUM_MASTERS-1:0]                  decerr_req;
    logic [NUM_SLAVES-1:0][NUM_MASTERS-1:0]  grant;
    logic [NUM_MASTERS-1:0]                  ready_merge;

    always_comb begin
        sel        = '0;
        decerr_req = '0;
        for (int m = 0; m < NUM_MASTERS; m++) begin
            sel[m]        = M_AXI_ARADDR[m*ADDR_WIDTH + ADDR_WIDTH-1 -: SEL_BITS];
            decerr_req[m] = M_AXI_ARVALID[m] && (int'(sel[m]) >= NUM_SLAVES);
        end
    end

    // Each master targets at most one slave, so at most one grant term is set.
    always_comb begin
        ready_merge = decerr_req;
        for (int s = 0; s < NUM_SLAVES; s++) begin
            ready_merge = ready_merge | grant[s];
        end
        M_AXI_ARREADY = ARESET ? '0 : ready_merge;
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            M_AXI_ARDECERR <= '0;
        end else begin
            M_AXI_ARDECERR <= decerr_req;
        end
    end

    for (genvar s = 0; s < NUM_SLAVES; s++) begin : g_slave
        state_t                 state, state_nxt;
        logic [MID_W-1:0]       last_q;
        logic [NUM_MASTERS-1:0] req;
        logic [MID_W-1:0]       pick;
        logic                   found;
        logic [NUM_MASTERS-1:0] gnt;
        logic [ADDR_WIDTH-1:0]  addr_p0;
        logic [2:0]             prot_p0;
        logic [MID_W-1:0]       mid_p0;

        always_comb begin
            req = '0;
            for (int m = 0; m < NUM_MASTERS; m++) begin
                req[m] = M_AXI_ARVALID[m] && (int'(sel[m]) == s);
            end
        end

        // Round-robin search starting just after the last granted master.
        always_comb begin
            pick  = last_q;
            found = 1'b0;
            for (int k = 1; k <= NUM_MASTERS; k++) begin
                if (!found && req[(int'(last_q) + k) % NUM_MASTERS]) begin
                    found = 1'b1;
                    pick  = MID_W'((int'(last_q) + k) % NUM_MASTERS);
                end
            end
        end

        always_ff @(posedge ACLK or posedge ARESET) begin
            if (ARESET) begin
                state <= IDLE;
            end else begin
                state <= state_nxt;
            end
        end

        always_comb begin
            state_nxt = state;
            case (state)
                IDLE:    if (found) state_nxt = BUSY;
                BUSY:    if (S_AXI_ARREADY[s]) state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end

        always_comb begin
            gnt = '0;
            if (state == IDLE && found) begin
                gnt[pick] = 1'b1;
            end
        end

        // Registered slave-side stage; loaded only on a grant, held while BUSY.
        always_ff @(posedge ACLK or posedge ARESET) begin
            if (ARESET) begin
                last_q  <= MID_W'(NUM_MASTERS - 1);
                addr_p0 <= '0;
                prot_p0 <= '0;
                mid_p0  <= '0;
            end else if (state == IDLE && found) begin
                last_q  <= pick;
                addr_p0 <= M_AXI_ARADDR[pick*ADDR_WIDTH +: ADDR_WIDTH];
                prot_p0 <= M_AXI_ARPROT[pick*3 +: 3];
                mid_p0  <= pick;
            end
        end

        assign grant[s]                               = gnt;
        assign S_AXI_ARVALID[s]                       = (state == BUSY);
        assign S_AXI_ARADDR[s*ADDR_WIDTH +: ADDR_WIDTH] = addr_p0;
        assign S_AXI_ARPROT[s*3 +: 3]                 = prot_p0;
        assign S_AXI_ARMID[s*MID_W +: MID_W]          = mid_p0;
    end

endmodule

// File: tb/tb_axi_ar_crossbar.sv
// Directed bench for axi_ar_crossbar: a 4-slave instance for the main function
// and a 3-slave instance for decode errors.
module tb_axi_ar_crossbar;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic [63:0] m_addr  = '0;
    logic [5:0]  m_prot  = '0;
    logic [1:0]  m_valid = '0;
    logic [1:0]  m_ready;
    logic [1:0]  m_decerr;
    logic [127:0] s_addr;
    logic [11:0] s_prot;
    logic [3:0]  s_mid;
    logic [3:0]  s_valid;
    logic [3:0]  s_ready = '0;

    logic [63:0] d3_m_addr  = '0;
    logic [5:0]  d3_m_prot  = '0;
    logic [1:0]  d3_m_valid = '0;
    logic [1:0]  d3_m_ready;
    logic [1:0]  d3_m_decerr;
    logic [95:0] d3_s_addr;
    logic [8:0]  d3_s_prot;
    logic [2:0]  d3_s_mid;
    logic [2:0]  d3_s_valid;
    logic [2:0]  d3_s_ready = '0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    axi_ar_crossbar #(.NUM_MASTERS(2), .NUM_SLAVES(4), .ADDR_WIDTH(32), .SEL_BITS(2)) dut (
        .ACLK(clk), .ARESET(rst),
        .M_AXI_ARADDR(m_addr), .M_AXI_ARPROT(m_prot), .M_AXI_ARVALID(m_valid),
        .M_AXI_ARREADY(m_ready), .M_AXI_ARDECERR(m_decerr),
        .S_AXI_ARADDR(s_addr), .S_AXI_ARPROT(s_prot), .S_AXI_ARMID(s_mid),
        .S_AXI_ARVALID(s_valid), .S_AXI_ARREADY(s_ready)
    );

    axi_ar_crossbar #(.NUM_MASTERS(2), .NUM_SLAVES(3), .ADDR_WIDTH(32), .SEL_BITS(2)) dut3 (
        .ACLK(clk), .ARESET(rst),
        .M_AXI_ARADDR(d3_m_addr), .M_AXI_ARPROT(d3_m_prot), .M_AXI_ARVALID(d3_m_valid),
        .M_AXI_ARREADY(d3_m_ready), .M_AXI_ARDECERR(d3_m_decerr),
        .S_AXI_ARADDR(d3_s_addr), .S_AXI_ARPROT(d3_s_prot), .S_AXI_ARMID(d3_s_mid),
        .S_AXI_ARVALID(d3_s_valid), .S_AXI_ARREADY(d3_s_ready)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_m(input int m, input logic [31:0] addr, input logic [2:0] prot, input logic vld);
        m_addr[m*32 +: 32] = addr;
        m_prot[m*3 +: 3]   = prot;
        m_valid[m]         = vld;
    endtask

    initial begin
        // Reset state, with a master already requesting
        set_m(0, 32'h4000_0000, 3'b000, 1'b1);
        tick();
        chk("rst_s_valid", s_valid, 4'b0000);
        chk("rst_m_ready", m_ready, 2'b00);
        chk("rst_decerr", m_decerr, 2'b00);
        chk("rst_s_addr", s_addr, 128'h0);
        m_valid = 2'b00;
        #2 rst = 1'b0;
        tick();

        // Single request M0 -> slave 1
        set_m(0, 32'h4000_1234, 3'b010, 1'b1);
        #1 chk("single_ready", m_ready, 2'b01);
        tick();
        m_valid = 2'b00;
        chk("single_valid", s_valid, 4'b0010);
        chk("single_addr", s_addr[32 +: 32], 32'h4000_1234);
        chk("single_prot", s_prot[3 +: 3], 3'b010);
        chk("single_mid", s_mid[1], 1'b0);
        s_ready[1] = 1'b1;
        tick();
        chk("single_clear", s_valid, 4'b0000);
        s_ready[1] = 1'b0;

        // Contention on slave 0 with ready held high
        s_ready[0] = 1'b1;
        set_m(0, 32'h0000_0000, 3'b001, 1'b1);
        set_m(1, 32'h0000_0010, 3'b011, 1'b1);
        for (int i = 0; i < 4; i++) begin
            #1 chk("cont_ready", m_ready, (i % 2) ? 2'b10 : 2'b01);
            tick();
            chk("cont_valid", s_valid[0], 1'b1);
            chk("cont_mid", s_mid[0], (i % 2) ? 1'b1 : 1'b0);
            chk("cont_busy_ready", m_ready, 2'b00);
            tick();
            chk("cont_idle", s_valid[0], 1'b0);
        end
        m_valid = 2'b00;
        s_ready[0] = 1'b0;

        // Backpressure on slave 2
        set_m(0, 32'h8000_00A0, 3'b001, 1'b1);
        #1 chk("bp_first_ready", m_ready, 2'b01);
        tick();
        m_valid = 2'b00;
        set_m(1, 32'h8000_00B0, 3'b100, 1'b1);
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp_hold_valid", s_valid[2], 1'b1);
            chk("bp_hold_addr", s_addr[64 +: 32], 32'h8000_00A0);
            chk("bp_m1_ready", m_ready, 2'b00);
            tick();
        end
        s_ready[2] = 1'b1;
        #1 chk("bp_hs_ready", m_ready, 2'b00);
        tick();
        s_ready[2] = 1'b0;
        chk("bp_release_valid", s_valid[2], 1'b0);
        chk("bp_m1_accept", m_ready, 2'b10);
        tick();
        m_valid = 2'b00;
        chk("bp_m1_valid", s_valid[2], 1'b1);
        chk("bp_m1_addr", s_addr[64 +: 32], 32'h8000_00B0);
        chk("bp_m1_prot", s_prot[6 +: 3], 3'b100);
        chk("bp_m1_mid", s_mid[2], 1'b1);
        s_ready[2] = 1'b1;
        tick();
        s_ready[2] = 1'b0;
        chk("bp_done", s_valid, 4'b0000);

        // Parallel slaves 0 and 3
        set_m(0, 32'h0000_0100, 3'b110, 1'b1);
        set_m(1, 32'hC000_0200, 3'b101, 1'b1);
        #1 chk("par_ready", m_ready, 2'b11);
        tick();
        m_valid = 2'b00;
        chk("par_valid", s_valid, 4'b1001);
        chk("par_addr0", s_addr[0 +: 32], 32'h0000_0100);
        chk("par_addr3", s_addr[96 +: 32], 32'hC000_0200);
        chk("par_mid3", s_mid[3], 1'b1);
        s_ready = 4'b1111;
        tick();
        s_ready = 4'b0000;
        chk("par_clear", s_valid, 4'b0000);

        // Decode error on the 3-slave instance
        d3_m_addr[32 +: 32] = 32'hC000_0000;
        d3_m_valid = 2'b10;
        #1;
        chk("dec_ready", d3_m_ready, 2'b10);
        chk("dec_no_early_err", d3_m_decerr, 2'b00);
        tick();
        d3_m_valid = 2'b00;
        chk("dec_err", d3_m_decerr, 2'b10);
        chk("dec_no_slave", d3_s_valid, 3'b000);
        tick();
        chk("dec_err_pulse", d3_m_decerr, 2'b00);
        chk("dec_no_slave2", d3_s_valid, 3'b000);

        // Reset while slave 1 is BUSY with M1's request
        set_m(1, 32'h4000_5678, 3'b111, 1'b1);
        tick();
        m_valid = 2'b00;
        chk("pre_rst_valid", s_valid[1], 1'b1);
        chk("pre_rst_mid", s_mid[1], 1'b1);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_valid", s_valid, 4'b0000);
        chk("async_rst_addr", s_addr, 128'h0);
        chk("async_rst_prot", s_prot, 12'h0);
        chk("async_rst_mid", s_mid, 4'h0);
        chk("async_rst_decerr", m_decerr, 2'b00);
        set_m(0, 32'h0000_0000, 3'b000, 1'b1);
        set_m(1, 32'h0000_0040, 3'b000, 1'b1);
        #1 chk("rst_ready_gated", m_ready, 2'b00);
        tick();
        chk("rst_hold_valid", s_valid, 4'b0000);
        #2 rst = 1'b0;
        #1 chk("post_rst_m0_wins", m_ready, 2'b01);
        tick();
        m_valid = 2'b00;
        chk("post_rst_mid", s_mid[0], 1'b0);
        chk("post_rst_valid", s_valid, 4'b0001);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
